axilite_cfg_master: RTL and testbench

AXI-Lite initiator that turns a simple single-beat command interface into write-address/write-data and read-address/read-data transactions toward the FIR configuration register slave. It sits between the testbench or CPU-side sequencer and the FIR block. It programs tap coefficients (0x080–0x0FF), data length (0x010) and ap_start (0x000), and reads back status and taps. The slave has no write-response channel, so a write completes once both its address and data handshakes have occurred.

---
 rtl/axilite_cfg_master.sv | 195 +++++++++++++++++++
 tb/tb_axilite_cfg_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_cfg_master.sv
// AXI-Lite initiator for the FIR configuration slave.
// Single outstanding transaction, no write-response channel.
module axilite_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata
);

    localparam int CW = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_A,
        READ_D,
        RESP
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   aw_done_q;
    logic                   w_done_q;
    logic                   cmd_ready_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   arvalid_q;
    logic                   rready_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [pDATA_WIDTH-1:0] wdata_q;
    logic [pDATA_WIDTH-1:0] rdata_q;

    logic aw_hs;
    logic w_hs;
    logic fin;
    logic in_bus;
    logic tmo;

    assign aw_hs  = awvalid_q & awready;
    assign w_hs   = wvalid_q & wready;
    assign tmo    = (cnt_q == CW'(pTIMEOUT - 1));
    assign in_bus = (state_q == WRITE) || (state_q == READ_A)
                 || (state_q == READ_D);

    // Completion of the current bus state, counting same-cycle handshakes.
    always_comb begin
        fin = 1'b0;
        unique case (state_q)
            WRITE:   fin = (aw_done_q | aw_hs) & (w_done_q | w_hs);
            READ_A:  fin = arvalid_q & arready;
            READ_D:  fin = rvalid;
            default: fin = 1'b0;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else if (in_bus && !fin && tmo) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        if (cmd_write) begin
                            state_q   <= WRITE;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= READ_A;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (fin) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (aw_hs) begin
                            awvalid_q <= 1'b0;
                            aw_done_q <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end
                    end
                end
                READ_A: begin
                    if (fin) begin
                        state_q   <= READ_D;
                        cnt_q     <= '0;
                        arvalid_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                READ_D: begin
                    if (fin) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        rready_q    <= 1'b0;
                        rdata_q     <= rdata;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign rready    = rready_q;

endmodule

// File: tb/tb_axilite_cfg_master.sv
// Randomized bench for axilite_cfg_master with a stalling slave model
// and a transaction-level reference of memory contents and latencies.
`timescale 1ns/1ps
module tb_axilite_cfg_master;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          awvalid, awready, wvalid, wready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;

    always #5 clk = ~clk;

    axilite_cfg_master #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .pTIMEOUT   (TMO)
    ) dut (
        .axis_clk  (clk),
        .axis_rst_n(rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata)
    );

    // Slave model: per-channel ready delays, registered rvalid.
    int aw_dly, w_dly, ar_dly, r_dly;
    int aw_wait, w_wait, ar_wait, r_cnt;
    bit r_pend;
    bit [31:0] smem [0:1023];
    bit        swr  [0:1023];

    function automatic logic [31:0] init_val(input int i);
        return 32'h9E3779B9 * 32'(i + 1);
    endfunction

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign arready = arvalid && (ar_wait >= ar_dly);
    assign rdata   = swr[araddr[11:2]] ? smem[araddr[11:2]]
                                       : init_val(int'(araddr[11:2]));

    always @(posedge clk) begin
        if (!rst_n || !awvalid || awready) aw_wait <= 0;
        else aw_wait <= aw_wait + 1;
        if (!rst_n || !wvalid || wready) w_wait <= 0;
        else w_wait <= w_wait + 1;
        if (!rst_n || !arvalid || arready) ar_wait <= 0;
        else ar_wait <= ar_wait + 1;
        if (rst_n && wvalid && wready) begin
            smem[awaddr[11:2]] <= wdata;
            swr[awaddr[11:2]]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            r_pend <= 1'b0;
            r_cnt  <= 0;
        end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready && rready) begin
                if (r_dly == 0) rvalid <= 1'b1;
                else begin
                    r_pend <= 1'b1;
                    r_cnt  <= r_dly;
                end
            end else if (r_pend) begin
                if (r_cnt == 1) begin
                    rvalid <= 1'b1;
                    r_pend <= 1'b0;
                end
                r_cnt <= r_cnt - 1;
            end
        end
    end

    // Protocol monitor
    bit mon_en = 1'b0;
    int ovl = 0;
    int rsp_cnt = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if ((awvalid || wvalid) && (arvalid || rready)) ovl <= ovl + 1;
            if (cmd_ready && (awvalid || wvalid || arvalid || rready || rsp_valid))
                ovl <= ovl + 1;
            if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model
    logic [31:0] ref_mem [0:1023];
    logic [31:0] last_rd;
    bit h_aw [0:63];
    bit h_w  [0:63];
    bit h_ar [0:63];
    bit h_rr [0:63];

    task automatic chk_reset(input string tag);
        check({tag, "_ctl"},
              64'({awvalid, wvalid, arvalid, rready, rsp_valid, rsp_err}), 64'd0);
        check({tag, "_rdy"}, 64'(cmd_ready), 64'd1);
        check({tag, "_addr"}, 64'({awaddr, araddr}), 64'd0);
        check({tag, "_wd"}, 64'(wdata), 64'd0);
        check({tag, "_rd"}, 64'(rsp_rdata), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input bit wr,
                           input logic [11:0] addr, input logic [31:0] data,
                           input bit blk);
        int lat, exp_lat, stab, rc0, n, mx;
        logic [31:0] exp_rd;
        if (blk) begin
            aw_dly = 100;
            w_dly  = 100;
            ar_dly = 100;
        end
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        exp_lat = blk ? TMO + 1 : (wr ? 2 + mx : 3 + ar_dly + r_dly);
        exp_rd  = blk ? 32'd0 : (wr ? last_rd : ref_mem[addr[11:2]]);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        rc0 = rsp_cnt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat  = 1;
        stab = 0;
        for (;;) begin
            h_aw[lat] = awvalid;
            h_w[lat]  = wvalid;
            h_ar[lat] = arvalid;
            h_rr[lat] = rready;
            if ((awvalid || wvalid) && (awaddr !== addr || wdata !== data))
                stab++;
            if ((arvalid || rready) && araddr !== addr) stab++;
            if (rsp_valid || lat >= 60) break;
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(rsp_err), 64'(blk));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        check({tag, "_stable"}, 64'(stab), 64'd0);
        check({tag, "_rsp_idle"},
              64'({awvalid, wvalid, arvalid, rready}), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'({rsp_valid, cmd_ready}), 64'd1);
        check({tag, "_rsp_cnt"}, 64'(rsp_cnt - rc0), 64'd1);
        if (!blk && wr) ref_mem[addr[11:2]] = data;
        last_rd = exp_rd;
        if (blk) begin
            aw_dly = 0;
            w_dly  = 0;
            ar_dly = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, rsp_at, lat, s;
        bit wr, blk;
        logic [11:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        last_rd   = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset("reset");
        mon_en = 1'b1;

        run_cmd("t1_wr080", 1'b1, 12'h080, 32'h0000_0005, 1'b0);
        check("t1_both_valid", 64'(h_aw[1] && h_w[1]), 64'd1);

        aw_dly = 3;
        run_cmd("t2_wr010", 1'b1, 12'h010, 32'h0000_0040, 1'b0);
        aw_dly = 0;
        check("t2_w_first", 64'(h_w[1]), 64'd1);
        check("t2_w_low", 64'(h_w[2]), 64'd0);
        check("t2_aw_c4", 64'(h_aw[4]), 64'd1);

        run_cmd("t3_rd010", 1'b0, 12'h010, 32'd0, 1'b0);
        check("t3_ar_rr", 64'({h_ar[1], h_rr[1]}), 64'd3);
        check("t3_rd_d", 64'({h_ar[2], h_rr[2]}), 64'd1);

        run_cmd("t4_tmo", 1'b0, 12'h010, 32'd0, 1'b1);
        check("t4_ar_c16", 64'(h_ar[TMO]), 64'd1);

        r_dly = 5;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h010;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_in_rd", 64'({arvalid, rready}), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset("t5_rst");
        r_dly = 0;
        last_rd = '0;
        run_cmd("t5_rd000", 1'b0, 12'h000, 32'd0, 1'b0);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h000;
        cmd_wdata = 32'd1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_write = 1'b0;
        cmd_wdata = 32'd0;
        n = 1;
        rsp_at = 0;
        while (!cmd_ready && n < 20) begin
            if (rsp_valid) rsp_at = n;
            @(posedge clk);
            #1 n++;
        end
        check("t6_gap", 64'(n), 64'd3);
        check("t6_rsp_at", 64'(rsp_at), 64'd2);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check("t6_rd_lat", 64'(lat), 64'd3);
        check("t6_rd_data", 64'(rsp_rdata), 64'd1);
        ref_mem[0] = 32'd1;
        last_rd = 32'd1;

        for (int k = 0; k < 50; k++) begin
            wr  = 1'($urandom_range(0, 1));
            blk = ($urandom_range(0, 11) == 0);
            s   = int'($urandom_range(0, 33));
            if (s == 32) a = 12'h000;
            else if (s == 33) a = 12'h010;
            else a = 12'h080 + 12'(s * 4);
            aw_dly = int'($urandom_range(0, 4));
            w_dly  = int'($urandom_range(0, 4));
            ar_dly = int'($urandom_range(0, 4));
            r_dly  = int'($urandom_range(0, 4));
            run_cmd("rnd", wr, a, $urandom, blk);
        end

        repeat (2) @(posedge clk);
        #1;
        check("no_overlap", 64'(ovl), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
